// File: rtl/falco_fetch_queue_if.sv
// Bus bundle for the fetch queue: instruction-memory request/response port,
// redirect input, and the decode-side valid/ready handshake.
interface falco_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_strobe;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_instr0;
  logic [31:0]       imem_instr1;
  logic              imem_v0;
  logic              imem_v1;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              dec_valid;
  logic [31:0]       dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;

  logic [CNT_W-1:0]  q_count;

  // Fetch-queue side.
  modport master (
    output imem_strobe, imem_addr, dec_valid, dec_instr, dec_pc, q_count,
    input  imem_ready, imem_instr0, imem_instr1, imem_v0, imem_v1,
           redirect_valid, redirect_pc, dec_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_strobe, imem_addr, dec_valid, dec_instr, dec_pc, q_count,
    output imem_ready, imem_instr0, imem_instr1, imem_v0, imem_v1,
           redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/falco_fetch_queue.sv
// Front-end fetch stage: issues paired instruction fetches, buffers the returned
// instructions in a circular FIFO and hands them to decode one per cycle.
// A redirect flushes the FIFO and restarts fetching at the new PC.
module falco_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  falco_fetch_queue_if.master bus
);
  localparam int                IDX_W      = $clog2(DEPTH);
  localparam int                CNT_W      = IDX_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  free_after;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx0;
  logic [IDX_W-1:0]  wr_idx1;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] addr_next;
  logic              strobe_q;
  logic              strobe_next;
  logic              empty;
  logic              deq;
  logic              fetch_ok;
  logic              resp_take;
  logic              flush;
  logic [1:0]        enq_n;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign count      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign deq        = !empty && bus.dec_ready;
  // Room for a full pair must exist after this cycle's dequeue before fetching.
  assign free_after = CNT_W'(DEPTH) - count + CNT_W'(deq);
  assign fetch_ok   = (free_after >= CNT_W'(2));
  // A response only lands when not overridden by a same-cycle redirect.
  assign resp_take  = (state == WAIT) && bus.imem_ready && !bus.redirect_valid;
  // In DROP the queue is already empty, so a redirect there only moves the PC.
  assign flush      = bus.redirect_valid && (state != DROP);
  assign enq_n      = resp_take ? (2'(bus.imem_v0) + 2'(bus.imem_v1)) : 2'd0;
  assign rd_idx     = rd_ptr[IDX_W-1:0];
  assign wr_idx0    = wr_ptr[IDX_W-1:0];
  // Lane 1 packs into slot 0 when lane 0 is invalid, keeping program order dense.
  assign wr_idx1    = wr_idx0 + IDX_W'(bus.imem_v0);

  // State register, with the request strobe and address registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      strobe_q <= 1'b0;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      strobe_q <= strobe_next;
      req_addr <= addr_next;
    end
  end

  // Next-state logic for the single-outstanding-request fetch FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!bus.redirect_valid && fetch_ok) state_next = WAIT;
      WAIT: begin
        if (bus.imem_ready)          state_next = IDLE;
        else if (bus.redirect_valid) state_next = DROP;
      end
      DROP: if (bus.imem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request outputs: launch a one-cycle strobe and latch the address until the response.
  always_comb begin
    strobe_next = (state == IDLE) && !bus.redirect_valid && fetch_ok;
    addr_next   = strobe_next ? fetch_pc : req_addr;
  end

  // Next fetch PC: redirect wins, otherwise step one pair past the returned response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ALIGN_MASK;
    end else if (resp_take) begin
      fetch_pc <= req_addr + ADDR_W'(8);
    end
  end

  // FIFO pointers: flush clears both, otherwise advance by enqueued and dequeued counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + CNT_W'(enq_n);
      rd_ptr <= rd_ptr + CNT_W'(deq);
    end
  end

  // FIFO storage: write the valid lanes of an accepted response with their PCs.
  always_ff @(posedge clk) begin
    if (resp_take && bus.imem_v0) begin
      instr_mem[wr_idx0] <= bus.imem_instr0;
      pc_mem[wr_idx0]    <= req_addr;
    end
    if (resp_take && bus.imem_v1) begin
      instr_mem[wr_idx1] <= bus.imem_instr1;
      pc_mem[wr_idx1]    <= req_addr + ADDR_W'(4);
    end
  end

  assign bus.imem_strobe = strobe_q;
  assign bus.imem_addr   = req_addr;
  assign bus.dec_valid   = !empty;
  assign bus.dec_instr   = empty ? 32'd0 : instr_mem[rd_idx];
  assign bus.dec_pc      = empty ? '0 : pc_mem[rd_idx];
  assign bus.q_count     = count;
endmodule

// File: tb/tb_falco_fetch_queue.sv
// Self-checking bench for falco_fetch_queue: the bench acts as instruction
// memory and decode, predicts the queue contents in a scoreboard and checks
// fetch addresses, ordering, flushes and backpressure.
module tb_falco_fetch_queue;
  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    logic [31:0] start_pc;
    int          latency;
    bit          v0;
    bit          v1;
    logic [31:0] exp_count;
    logic [31:0] exp_next;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  falco_fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  falco_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int          pass_count  = 0;
  int          check_count = 0;
  entry_t      sb[$];
  bit          outstanding;
  bit          dropping;
  bit          lane_v0;
  bit          lane_v1;
  bit          random_lat;
  int          wait_cnt;
  int          latency;
  int          strobe_count;
  int          pop_count;
  int          ready_mode;
  logic [31:0] exp_fetch;
  logic [31:0] req_addr;
  vec_t        vecs[6];

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    else
      pass_count++;
  endtask

  // One clock cycle: observe outputs at the negedge, then drive the next inputs.
  task automatic cycle(input bit do_redirect, input logic [31:0] rpc);
    entry_t e;
    bit     respond;
    @(negedge clk);
    checkOutput("q_count_model", 32'(bus.q_count), 32'(sb.size()));
    checkOutput("q_count_bound", 32'(bus.q_count <= DEPTH), 32'd1);
    checkOutput("dec_valid_model", 32'(bus.dec_valid), 32'(sb.size() != 0));
    if (bus.dec_valid) checkOutput("dec_pc_align", 32'(bus.dec_pc[1:0]), 32'd0);
    if (bus.imem_strobe) begin
      checkOutput("strobe_while_busy", 32'(outstanding), 32'd0);
      checkOutput("strobe_addr", bus.imem_addr, exp_fetch);
      outstanding = 1'b1;
      dropping    = 1'b0;
      wait_cnt    = 0;
      req_addr    = exp_fetch;
      strobe_count++;
      if (random_lat) latency = $urandom_range(1, 4);
    end else if (outstanding) begin
      wait_cnt++;
      checkOutput("addr_hold", bus.imem_addr, req_addr);
    end

    respond = outstanding && (wait_cnt >= latency);
    case (ready_mode)
      1:       bus.dec_ready = 1'b1;
      2:       bus.dec_ready = 1'($urandom_range(0, 1));
      default: bus.dec_ready = 1'b0;
    endcase
    if (bus.dec_valid && bus.dec_ready && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("dec_instr", bus.dec_instr, e.instr);
      checkOutput("dec_pc", bus.dec_pc, e.pc);
      pop_count++;
    end
    bus.imem_ready  = respond;
    bus.imem_v0     = respond & lane_v0;
    bus.imem_v1     = respond & lane_v1;
    bus.imem_instr0 = instrOf(req_addr);
    bus.imem_instr1 = instrOf(req_addr + 32'd4);
    if (respond) begin
      if (!dropping && !do_redirect) begin
        if (lane_v0) sb.push_back('{instr: instrOf(req_addr), pc: req_addr});
        if (lane_v1) sb.push_back('{instr: instrOf(req_addr + 32'd4), pc: req_addr + 32'd4});
        exp_fetch = req_addr + 32'd8;
      end
      outstanding = 1'b0;
      dropping    = 1'b0;
    end
    bus.redirect_valid = do_redirect;
    bus.redirect_pc    = rpc;
    if (do_redirect) begin
      if (outstanding) dropping = 1'b1;
      sb.delete();
      exp_fetch = rpc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic waitStrobes(input int target, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && strobe_count < target; i++) cycle(1'b0, 32'd0);
    checkOutput(name, 32'(strobe_count), 32'(target));
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst                = 1'b1;
    bus.imem_ready     = 1'b0;
    bus.imem_v0        = 1'b0;
    bus.imem_v1        = 1'b0;
    bus.imem_instr0    = 32'd0;
    bus.imem_instr1    = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.dec_ready      = 1'b0;
    sb.delete();
    outstanding  = 1'b0;
    dropping     = 1'b0;
    random_lat   = 1'b0;
    wait_cnt     = 0;
    latency      = 1;
    strobe_count = 0;
    pop_count    = 0;
    ready_mode   = 0;
    lane_v0      = 1'b1;
    lane_v1      = 1'b1;
    exp_fetch    = RESET_PC;
    req_addr     = RESET_PC;
    repeat (2) @(negedge clk);
    checkOutput("rst_strobe", 32'(bus.imem_strobe), 32'd0);
    checkOutput("rst_addr", bus.imem_addr, RESET_PC);
    checkOutput("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    checkOutput("rst_dec_instr", bus.dec_instr, 32'd0);
    checkOutput("rst_dec_pc", bus.dec_pc, 32'd0);
    checkOutput("rst_q_count", 32'(bus.q_count), 32'd0);
    rst = 1'b0;
  endtask

  // Table vector: redirect to a start PC, take one response, check occupancy and next fetch.
  task automatic applyStimulus(input vec_t v);
    int base;
    ready_mode = 0;
    latency    = v.latency;
    lane_v0    = v.v0;
    lane_v1    = v.v1;
    cycle(1'b1, v.start_pc);
    base = strobe_count;
    waitStrobes(base + 1, 40, "vec_first_strobe");
    checkOutput("vec_first_addr", bus.imem_addr, v.start_pc & 32'hFFFF_FFFC);
    waitStrobes(base + 2, 40, "vec_second_strobe");
    checkOutput("vec_q_count", 32'(bus.q_count), v.exp_count);
    checkOutput("vec_next_addr", bus.imem_addr, v.exp_next);
    ready_mode = 1;
    repeat (6) cycle(1'b0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    vecs[0] = '{start_pc: 32'h0000_0040, latency: 1, v0: 1'b1, v1: 1'b1, exp_count: 32'd2, exp_next: 32'h0000_0048};
    vecs[1] = '{start_pc: 32'h0000_0020, latency: 2, v0: 1'b1, v1: 1'b0, exp_count: 32'd1, exp_next: 32'h0000_0028};
    vecs[2] = '{start_pc: 32'h0000_0103, latency: 3, v0: 1'b1, v1: 1'b1, exp_count: 32'd2, exp_next: 32'h0000_0108};
    vecs[3] = '{start_pc: 32'h0000_0204, latency: 1, v0: 1'b0, v1: 1'b1, exp_count: 32'd1, exp_next: 32'h0000_020C};
    vecs[4] = '{start_pc: 32'h0000_0300, latency: 4, v0: 1'b0, v1: 1'b0, exp_count: 32'd0, exp_next: 32'h0000_0308};
    vecs[5] = '{start_pc: 32'hFFFF_FFF8, latency: 1, v0: 1'b1, v1: 1'b1, exp_count: 32'd2, exp_next: 32'h0000_0000};

    // Reset, first strobe on the first edge, pair returned in order.
    applyReset();
    ready_mode = 1;
    latency    = 1;
    cycle(1'b0, 32'd0);
    checkOutput("t1_first_strobe", 32'(strobe_count), 32'd1);
    checkOutput("t1_first_addr", bus.imem_addr, RESET_PC);
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
    checkOutput("t1_head_pc", bus.dec_pc, 32'd0);
    checkOutput("t1_head_instr", bus.dec_instr, instrOf(32'd0));
    repeat (5) cycle(1'b0, 32'd0);
    checkOutput("t1_dequeued", 32'(pop_count >= 2), 32'd1);

    // Table-driven single transactions, including partial lanes and PC wrap.
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Backpressure: four fetches fill the queue, refetch needs two free slots.
    applyReset();
    ready_mode = 0;
    latency    = 1;
    repeat (60) cycle(1'b0, 32'd0);
    checkOutput("t2_fetches", 32'(strobe_count), 32'd4);
    checkOutput("t2_full_count", 32'(bus.q_count), 32'd8);
    ready_mode = 1;
    cycle(1'b0, 32'd0);
    ready_mode = 0;
    repeat (10) cycle(1'b0, 32'd0);
    checkOutput("t2_hold_after_one", 32'(strobe_count), 32'd4);
    ready_mode = 1;
    cycle(1'b0, 32'd0);
    ready_mode = 0;
    waitStrobes(5, 10, "t2_refetch");
    checkOutput("t2_refetch_addr", bus.imem_addr, 32'h0000_0020);

    // Redirect while waiting: the 0x40 response is dropped, restart at 0x100.
    applyReset();
    ready_mode = 0;
    latency    = 1;
    cycle(1'b1, 32'h0000_0038);
    base = strobe_count;
    waitStrobes(base + 1, 20, "t3_strobe_38");
    cycle(1'b0, 32'd0);
    latency = 5;
    waitStrobes(base + 2, 20, "t3_strobe_40");
    checkOutput("t3_addr_40", bus.imem_addr, 32'h0000_0040);
    checkOutput("t3_count_before", 32'(bus.q_count), 32'd2);
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0103);
    cycle(1'b0, 32'd0);
    checkOutput("t3_flushed_count", 32'(bus.q_count), 32'd0);
    checkOutput("t3_flushed_valid", 32'(bus.dec_valid), 32'd0);
    latency    = 2;
    ready_mode = 1;
    waitStrobes(base + 3, 20, "t3_restart");
    checkOutput("t3_restart_addr", bus.imem_addr, 32'h0000_0100);
    base = pop_count;
    repeat (6) cycle(1'b0, 32'd0);
    checkOutput("t3_restart_popped", 32'(pop_count - base >= 2), 32'd1);

    // Redirect coincident with the response: no DROP, restart two cycles later.
    applyReset();
    ready_mode = 0;
    latency    = 2;
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0500);
    base = strobe_count;
    waitStrobes(base + 1, 3, "t4_no_drop_restart");
    checkOutput("t4_addr", bus.imem_addr, 32'h0000_0500);
    checkOutput("t4_q_count", 32'(bus.q_count), 32'd0);

    // Random stalls and latencies across the address wrap.
    applyReset();
    random_lat = 1'b1;
    ready_mode = 2;
    cycle(1'b1, 32'hFFFF_FFE0);
    repeat (1000) cycle(1'b0, 32'd0);
    checkOutput("t6_progress", 32'(pop_count > 100), 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
